uart_tx_arbiter: RTL

- Shares one uart_tx serializer between NUM_REQ byte producers (debug console, status reporter, loopback echo, etc.) using round-robin arbitration.
- Captures one byte from the granted requester and launches it with a single-cycle tx_dv pulse.
- Tracks the serializer through tx_active and tx_done, then re-arbitrates.
- Sits between the requester logic and the uart_tx instance, and drives that instance's tx_dv and tx_byte inputs.

---
 rtl/uart_tx_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one uart_tx serializer between NUM_REQ
//   byte producers. It captures one byte from the winning requester, launches
//   it with a single-cycle tx_dv pulse, follows the serializer through
//   tx_active / tx_done, and returns to arbitration once tx_done has dropped.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   IDX_W    width of grant index / priority pointer (2**IDX_W >= NUM_REQ)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   req_valid  per-requester byte-available flags
//   req_byte   per-requester bytes, requester i on [8i+7:8i]
//   req_last   (UART_ARB_LOCK_EN only) last byte of a locked burst
//   req_ready  one-hot capture pulse
//   grant      one-hot owner of the current transaction, zero when idle
//   tx_dv      launch pulse to uart_tx
//   tx_byte    byte to uart_tx, held from capture to end of transaction
//   tx_active  uart_tx busy indication
//   tx_done    uart_tx completion indication (may last 2 cycles)
//   busy       high whenever the arbiter is not arbitrating
//
// Optional build macro
//   UART_ARB_LOCK_EN  adds req_last; a byte captured with req_last=0 locks the
//                     arbiter to that requester until a byte with req_last=1.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_byte,
`ifdef UART_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]     req_last,
`endif
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   tx_dv,
   output logic [7:0]             tx_byte,
   input  logic                   tx_active,
   input  logic                   tx_done,
   output logic                   busy
);

   typedef enum logic [2:0] {ARB, LAUNCH, WAIT_ACT, WAIT_DONE, WAIT_CLR} state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [7:0]           byte_q, byte_d;
   logic [1:0]           wait_q, wait_d;

   logic [NUM_REQ-1:0]   eligible;
   logic [2*NUM_REQ-1:0] rot;
   logic                 found;
   int unsigned          off;
   int unsigned          sum;
   logic [IDX_W-1:0]     win_next;
   logic [NUM_REQ-1:0]   win_oh;
   logic [7:0]           win_byte;

`ifdef UART_ARB_LOCK_EN
   logic                 lock_q, lock_d;
   logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;
   logic [NUM_REQ-1:0]   lock_mask;
   logic [IDX_W-1:0]     win_idx;
   logic                 win_last;
`endif

   // Round-robin pick: rotate the eligible vector so the pointer lands on bit 0,
   // take the first set bit, then map the offset back to a requester index.
   always_comb begin
      eligible = req_valid;
`ifdef UART_ARB_LOCK_EN
      lock_mask = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         lock_mask[k] = (lock_idx_q == IDX_W'(k));
      end
      if (lock_q) begin
         eligible = req_valid & lock_mask;
      end
`endif
      rot   = {eligible, eligible} >> ptr_q;
      found = 1'b0;
      off   = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            off   = i;
         end
      end
      sum = 32'(ptr_q) + off;
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end
      win_next = (sum == NUM_REQ - 1) ? '0 : IDX_W'(sum + 1);
      win_oh   = '0;
      win_byte = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (found && sum == k) begin
            win_oh[k] = 1'b1;
            win_byte  = req_byte[8*k +: 8];
         end
      end
`ifdef UART_ARB_LOCK_EN
      win_idx  = IDX_W'(sum);
      win_last = |(req_last & win_oh);
`endif
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB;
         ptr_q   <= '0;
         grant_q <= '0;
         byte_q  <= '0;
         wait_q  <= '0;
`ifdef UART_ARB_LOCK_EN
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         byte_q  <= byte_d;
         wait_q  <= wait_d;
`ifdef UART_ARB_LOCK_EN
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB:       if (found) state_d = LAUNCH;
         LAUNCH:    state_d = WAIT_ACT;
         // Launch counts as the first of four cycles; three silent waits re-launch.
         WAIT_ACT: begin
            if (tx_active)           state_d = WAIT_DONE;
            else if (wait_q == 2'd2) state_d = LAUNCH;
         end
         WAIT_DONE: if (tx_done)  state_d = WAIT_CLR;
         WAIT_CLR:  if (!tx_done) state_d = ARB;
         default:   state_d = ARB;
      endcase
   end

   // Datapath next values
   always_comb begin
      ptr_d   = ptr_q;
      grant_d = grant_q;
      byte_d  = byte_q;
      wait_d  = wait_q;
`ifdef UART_ARB_LOCK_EN
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
`endif
      unique case (state_q)
         ARB: begin
            if (found) begin
               grant_d = win_oh;
               byte_d  = win_byte;
`ifdef UART_ARB_LOCK_EN
               // Pointer stays put while locked; release advances past the owner.
               if (win_last) begin
                  lock_d = 1'b0;
                  ptr_d  = win_next;
               end else begin
                  lock_d     = 1'b1;
                  lock_idx_d = win_idx;
               end
`else
               ptr_d = win_next;
`endif
            end
         end
         LAUNCH:   wait_d = '0;
         WAIT_ACT: if (!tx_active) wait_d = wait_q + 2'd1;
         WAIT_CLR: if (!tx_done) grant_d = '0;
         default:  ;
      endcase
   end

   // Outputs
   always_comb begin
      req_ready = (state_q == ARB) ? win_oh : '0;
      tx_dv     = (state_q == LAUNCH);
      busy      = (state_q != ARB);
      grant     = grant_q;
      tx_byte   = byte_q;
   end

endmodule
